// File: rtl/register_file_mp_if.sv
// Port bundle for register_file_mp: clear control, one write port and two read ports.
// The master drives requests and the slave (the register file) returns read data and busy.
interface register_file_mp_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4
);
  logic              clr_req;
  logic              busy;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              re_a;
  logic [ADDR_W-1:0] raddr_a;
  logic [DATA_W-1:0] rdata_a;
  logic              rvalid_a;
  logic              re_b;
  logic [ADDR_W-1:0] raddr_b;
  logic [DATA_W-1:0] rdata_b;
  logic              rvalid_b;

  modport master (
    output clr_req, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    input  busy, rdata_a, rvalid_a, rdata_b, rvalid_b
  );

  modport slave (
    input  clr_req, we, waddr, wdata, re_a, raddr_a, re_b, raddr_b,
    output busy, rdata_a, rvalid_a, rdata_b, rvalid_b
  );
endinterface

// File: rtl/register_file_mp.sv
// Multi-port register file: two registered read ports with write bypass, one write port,
// optional hardwired-zero r0, and a one-row-per-cycle clear sweep after reset or on request.
module register_file_mp #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = 4,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  register_file_mp_if.slave    bus
);

  localparam int unsigned   AddrW1   = ADDR_W + 1;
  localparam logic [ADDR_W:0]   NumRegsW = AddrW1'(NUM_REGS);
  localparam logic [ADDR_W-1:0] LastPtr  = ADDR_W'(NUM_REGS - 1);
  localparam bit                ZeroEn   = (ZERO_REG != 0);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
  logic              rvalid_a_q, rvalid_a_d, rvalid_b_q, rvalid_b_d;
  logic [DATA_W-1:0] rd_val_a, rd_val_b;
  logic              idle, wr_ok;

  // Addresses that read as zero are exactly the ones whose writes are dropped.
  function automatic logic addr_masked(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} >= NumRegsW) || (ZeroEn && (a == '0));
  endfunction

  assign idle  = (state_q == StIdle);
  assign wr_ok = idle && bus.we && !addr_masked(bus.waddr);

  always_comb begin
    rd_val_a = '0;
    if (!addr_masked(bus.raddr_a)) begin
      if (wr_ok && (bus.waddr == bus.raddr_a)) rd_val_a = bus.wdata;
      else                                     rd_val_a = regs_q[bus.raddr_a];
    end
  end

  always_comb begin
    rd_val_b = '0;
    if (!addr_masked(bus.raddr_b)) begin
      if (wr_ok && (bus.waddr == bus.raddr_b)) rd_val_b = bus.wdata;
      else                                     rd_val_b = regs_q[bus.raddr_b];
    end
  end

  always_comb begin
    state_d    = state_q;
    clr_ptr_d  = clr_ptr_q;
    rdata_a_d  = rdata_a_q;
    rdata_b_d  = rdata_b_q;
    rvalid_a_d = 1'b0;
    rvalid_b_d = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_ptr_d = clr_ptr_q + 1'b1;
        if (clr_ptr_q == LastPtr) begin
          state_d   = StIdle;
          clr_ptr_d = '0;
        end
      end
      StIdle: begin
        if (bus.re_a) begin
          rvalid_a_d = 1'b1;
          rdata_a_d  = rd_val_a;
        end
        if (bus.re_b) begin
          rvalid_b_d = 1'b1;
          rdata_b_d  = rd_val_b;
        end
        if (bus.clr_req) begin
          state_d   = StClear;
          clr_ptr_d = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StClear;
      clr_ptr_q  <= '0;
      rdata_a_q  <= '0;
      rdata_b_q  <= '0;
      rvalid_a_q <= 1'b0;
      rvalid_b_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_ptr_q  <= clr_ptr_d;
      rdata_a_q  <= rdata_a_d;
      rdata_b_q  <= rdata_b_d;
      rvalid_a_q <= rvalid_a_d;
      rvalid_b_q <= rvalid_b_d;
    end
  end

  // No reset on the array: stale rows survive rst until the sweep reaches them.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state_q == StClear) regs_q[clr_ptr_q] <= '0;
      else if (wr_ok)         regs_q[bus.waddr] <= bus.wdata;
    end
  end

  assign bus.busy     = (state_q == StClear);
  assign bus.rdata_a  = rdata_a_q;
  assign bus.rdata_b  = rdata_b_q;
  assign bus.rvalid_a = rvalid_a_q;
  assign bus.rvalid_b = rvalid_b_q;

endmodule
